// File: rtl/ce_meter_pkg.sv
// rtl/ce_meter_pkg.sv - shared state encoding and parameter defaults for the CE period meter
package ce_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_MEASURE    = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W      = 17;
  localparam int unsigned DEF_EXP_PERIOD = 100000;
  localparam int unsigned DEF_TOL        = 2;
  localparam int unsigned DEF_LOCK_N     = 4;

endpackage

// File: rtl/ce_edge_det.sv
// rtl/ce_edge_det.sv - rising-edge detector; a level held high yields a single RISE
module ce_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic RISE
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = D;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign RISE = D & ~prev_q;

endmodule

// File: rtl/ce_period_meter.sv
// rtl/ce_period_meter.sv - measures CE_IN strobe period, flags overrun/timeout, tracks lock
module ce_period_meter
  import ce_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_N     = DEF_LOCK_N
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CE_IN,
  input  logic             READY,
  output logic [CNT_W-1:0] PERIOD,
  output logic             VALID,
  output logic             OVERRUN,
  output logic             TIMEOUT,
  output logic             LOCKED
);

  localparam int unsigned      LK_W      = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LO_BOUND  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_BOUND  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [LK_W-1:0]  LOCK_FULL = LK_W'(LOCK_N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;

  logic rise;
  logic first_edge;
  logic load;
  logic tmo;
  logic in_range;

  ce_edge_det u_edge_det (
    .CLK  (CLK),
    .RST  (RST),
    .D    (CE_IN),
    .RISE (rise)
  );

  // An edge coinciding with a saturated count is a valid measurement, so it blocks the timeout.
  assign first_edge = EN && (state_q == ST_WAIT_FIRST) && rise;
  assign load       = EN && (state_q == ST_MEASURE) && rise;
  assign tmo        = EN && (state_q == ST_MEASURE) && !rise && (cnt_q == CNT_MAX);
  assign in_range   = (cnt_q >= LO_BOUND) && (cnt_q <= HI_BOUND);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_FIRST;
        ST_WAIT_FIRST: if (rise) state_d = ST_MEASURE;
        ST_MEASURE:    if (tmo) state_d = ST_WAIT_FIRST;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = '0;
    period_d   = period_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    timeout_d  = tmo;
    lock_cnt_d = lock_cnt_q;

    if (first_edge || load) begin
      cnt_d = CNT_W'(1);
    end else if (EN && (state_q == ST_MEASURE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!EN) begin
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
      lock_cnt_d = '0;
    end else if (load) begin
      period_d = cnt_q;
      valid_d  = 1'b1;
      if (valid_q && !READY) begin
        overrun_d = 1'b1;
      end
      if (!in_range) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LOCK_FULL) begin
        lock_cnt_d = lock_cnt_q + LK_W'(1);
      end
    end else begin
      if (valid_q && READY) begin
        valid_d = 1'b0;
      end
      if (tmo) begin
        lock_cnt_d = '0;
      end
    end

    locked_d = (lock_cnt_d == LOCK_FULL);
  end

  assign PERIOD  = period_q;
  assign VALID   = valid_q;
  assign OVERRUN = overrun_q;
  assign TIMEOUT = timeout_q;
  assign LOCKED  = locked_q;

endmodule
